// File: rtl/axi_pwm_gen_mc.sv
// axi_pwm_gen_mc: multi-channel PWM generator behind an AXI4-Lite register file.
// One shared up / up-down period counter feeds NUM_CH duty comparators.
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*       AXI4-Lite write address, data and response channels
//   S_AXI_AR*/R*          AXI4-Lite read address and data channels
//   pwm_out[NUM_CH]       registered PWM outputs
//   period_irq            level interrupt, STATUS.PEND & CTRL.IE
module axi_pwm_gen_mc #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_CH             = 4,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_CH-1:0]               pwm_out,
  output logic                            period_irq
);

  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  localparam cnt_t ONE = cnt_t'(1);

  logic              en;
  logic              center;
  logic              ie;
  logic              upd;
  logic              pend;
  cnt_t              period_sh;
  cnt_t              period_act;
  cnt_t              duty_sh  [NUM_CH];
  cnt_t              duty_act [NUM_CH];
  logic [NUM_CH-1:0] pol;

  state_t state;
  state_t state_nxt;
  cnt_t   cnt;
  cnt_t   cnt_nxt;
  logic   wrap;

  logic          aw_hs;
  logic          ar_hs;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [DW-1:0] wr_old;
  logic [DW-1:0] wr_val;
  logic [DW-1:0] rd_val;
  logic          wr_ok;
  logic          rd_ok;
  logic          unused;

  assign wr_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign aw_hs  = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID;
  assign ar_hs  = S_AXI_ARREADY & S_AXI_ARVALID;
  assign unused = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], wr_val};

  assign period_irq = pend & ie;

  // Register readback; ok=0 marks an unmapped word.
  function automatic logic [DW-1:0] reg_mux(
    input  logic [IW-1:0] idx,
    output logic          ok
  );
    logic [DW-1:0] v;
    v  = '0;
    ok = 1'b1;
    case (int'(idx))
      0: v[2:0] = {ie, center, en};
      1: v = DW'(period_sh);
      2: v[0] = pend;
      3: v = DW'(pol);
      default: begin
        ok = 1'b0;
        for (int n = 0; n < NUM_CH; n++) begin
          if (int'(idx) == n + 4) begin
            v  = DW'(duty_sh[n]);
            ok = 1'b1;
          end
        end
      end
    endcase
    return v;
  endfunction

  always_comb begin
    rd_val = reg_mux(rd_idx, rd_ok);
  end

  // Byte-strobe merge onto the current register contents.
  always_comb begin
    wr_old = reg_mux(wr_idx, wr_ok);
    wr_val = wr_old;
    for (int b = 0; b < DW / 8; b++) begin
      if (S_AXI_WSTRB[b]) wr_val[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= OKAY;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= OKAY;
    end else begin
      S_AXI_AWREADY <= S_AXI_AWVALID & S_AXI_WVALID &
                       ~S_AXI_BVALID & ~S_AXI_AWREADY;
      S_AXI_WREADY  <= S_AXI_AWVALID & S_AXI_WVALID &
                       ~S_AXI_BVALID & ~S_AXI_AWREADY;
      if (aw_hs) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_ok ? OKAY : SLVERR;
      end else if (S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
      S_AXI_ARREADY <= S_AXI_ARVALID & ~S_AXI_RVALID & ~S_AXI_ARREADY;
      if (ar_hs) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_val;
        S_AXI_RRESP  <= rd_ok ? OKAY : SLVERR;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      en         <= 1'b0;
      center     <= 1'b0;
      ie         <= 1'b0;
      upd        <= 1'b0;
      pend       <= 1'b0;
      period_sh  <= '0;
      period_act <= '0;
      pol        <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        duty_sh[n]  <= '0;
        duty_act[n] <= '0;
      end
    end else begin
      if (aw_hs && wr_ok) begin
        case (int'(wr_idx))
          0: begin
            en     <= wr_val[0];
            center <= wr_val[1];
            ie     <= wr_val[2];
            if (wr_val[3] && en) upd <= 1'b1;
          end
          1: period_sh <= cnt_t'(wr_val);
          2: if (S_AXI_WSTRB[0] && S_AXI_WDATA[0]) pend <= 1'b0;
          3: pol <= wr_val[NUM_CH-1:0];
          default: begin
            for (int n = 0; n < NUM_CH; n++) begin
              if (int'(wr_idx) == n + 4) duty_sh[n] <= cnt_t'(wr_val);
            end
          end
        endcase
      end
      // A wrap overrides a same-cycle W1C so no period is missed.
      if (wrap) pend <= 1'b1;
      if (state == IDLE) begin
        period_act <= period_sh;
        duty_act   <= duty_sh;
        upd        <= 1'b0;
      end else if (wrap && upd) begin
        period_act <= period_sh;
        duty_act   <= duty_sh;
        upd        <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wrap      = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (en) state_nxt = UP;
      end
      UP: begin
        if (!en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (period_act == '0) begin
          cnt_nxt = '0;
        end else if (cnt == period_act) begin
          // PERIOD=1 in centre mode has no interior DOWN count.
          if (center && period_act != ONE) begin
            state_nxt = DOWN;
            cnt_nxt   = cnt - ONE;
          end else begin
            cnt_nxt = '0;
            wrap    = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      DOWN: begin
        if (!en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - ONE;
          if (cnt == ONE) begin
            state_nxt = UP;
            wrap      = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      pwm_out <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        pwm_out[n] <= (state != IDLE && period_act != '0 &&
                       cnt < duty_act[n]) ^ pol[n];
      end
    end
  end

endmodule
